// File: rtl/ahb_pkg.sv
// Shared AHB-Lite constants and bridge FSM encoding for lsu_ahb_master.
// Optional build macro: LSU_AHB_ALIGN_CHECK_EN (see lsu_ahb_master.sv).
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10
    } state_e;

    // size is already normalised (3 folded to word)
    function automatic logic misaligned(input logic [1:0] size,
                                        input logic [1:0] lo);
        return ((size == 2'd1) && lo[0]) ||
               ((size == 2'd2) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_ahb_master_if.sv
// LSU request/grant port plus AHB-Lite master signals of the bridge.
// master modport = bridge view, slave modport = LSU/bus environment view.
interface lsu_ahb_master_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic              req_i;
    logic              we_i;
    logic [AWIDTH-1:0] addr_i;
    logic [1:0]        size_i;
    logic [DWIDTH-1:0] wdata_i;
    logic              gnt_o;
    logic              rvalid_o;
    logic [DWIDTH-1:0] rdata_o;
    logic              err_o;
    logic [AWIDTH-1:0] haddr_o;
    logic [1:0]        htrans_o;
    logic              hwrite_o;
    logic [2:0]        hsize_o;
    logic [2:0]        hburst_o;
    logic [DWIDTH-1:0] hwdata_o;
    logic              hready_i;
    logic              hresp_i;
    logic [DWIDTH-1:0] hrdata_i;

    modport master (
        input  req_i, we_i, addr_i, size_i, wdata_i,
        input  hready_i, hresp_i, hrdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o,
        output haddr_o, htrans_o, hwrite_o, hsize_o,
        output hburst_o, hwdata_o
    );

    modport slave (
        output req_i, we_i, addr_i, size_i, wdata_i,
        output hready_i, hresp_i, hrdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o,
        input  haddr_o, htrans_o, hwrite_o, hsize_o,
        input  hburst_o, hwdata_o
    );
endinterface

// File: rtl/ahb_lane_align.sv
// Byte-lane handling: write data replication and read data extraction.
// Purely combinational; size 3 is treated as word.
module ahb_lane_align
    import ahb_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [1:0]        size_i,
    input  logic [1:0]        addr_lo_i,
    input  logic [DWIDTH-1:0] wdata_i,
    input  logic [DWIDTH-1:0] hrdata_i,
    output logic [DWIDTH-1:0] hwdata_o,
    output logic [DWIDTH-1:0] rdata_o
);

    logic [DWIDTH-1:0] byte_sh;
    logic [DWIDTH-1:0] half_sh;

    assign byte_sh = hrdata_i >> {addr_lo_i, 3'b000};
    assign half_sh = hrdata_i >> {addr_lo_i[1], 4'b0000};

    // replicate narrow stores across lanes, extract narrow loads
    always_comb begin
        hwdata_o = wdata_i;
        rdata_o  = hrdata_i;
        unique case ({1'b0, size_i})
            HSIZE_BYTE: begin
                hwdata_o = {4{wdata_i[7:0]}};
                rdata_o  = {{(DWIDTH-8){1'b0}}, byte_sh[7:0]};
            end
            HSIZE_HALF: begin
                hwdata_o = {2{wdata_i[15:0]}};
                rdata_o  = {{(DWIDTH-16){1'b0}}, half_sh[15:0]};
            end
            default: begin
                hwdata_o = wdata_i;
                rdata_o  = hrdata_i;
            end
        endcase
    end

endmodule

// File: rtl/lsu_ahb_master.sv
// Single-outstanding LSU to AHB-Lite bridge (SINGLE bursts, 2-cycle ERROR).
// Macro LSU_AHB_ALIGN_CHECK_EN: fail misaligned requests locally, no bus cycle.
module lsu_ahb_master
    import ahb_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input logic             hclk,
    input logic             hresetn,
    lsu_ahb_master_if.master bus
);

    state_e            state_q, state_d;
    logic [1:0]        htrans_q, htrans_d;
    logic [AWIDTH-1:0] haddr_q, haddr_d;
    logic              hwrite_q, hwrite_d;
    logic [2:0]        hsize_q, hsize_d;
    logic [DWIDTH-1:0] hwdata_q, hwdata_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic              rvalid_q, rvalid_d;
    logic              err_q, err_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;

    logic [1:0]        size_n;
    logic              mis_req;
    logic [DWIDTH-1:0] lane_wdata;
    logic [DWIDTH-1:0] lane_rdata;

    assign size_n = (bus.size_i == 2'd3) ? 2'd2 : bus.size_i;

`ifdef LSU_AHB_ALIGN_CHECK_EN
    assign mis_req = misaligned(size_n, bus.addr_i[1:0]);
`else
    assign mis_req = 1'b0;
`endif

    ahb_lane_align #(.DWIDTH(DWIDTH)) u_align (
        .size_i   (hsize_q[1:0]),
        .addr_lo_i(haddr_q[1:0]),
        .wdata_i  (wdata_q),
        .hrdata_i (bus.hrdata_i),
        .hwdata_o (lane_wdata),
        .rdata_o  (lane_rdata)
    );

    // state and registered outputs
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_q  <= ST_IDLE;
            htrans_q <= HTRANS_IDLE;
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            hsize_q  <= 3'b000;
            hwdata_q <= '0;
            wdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            htrans_q <= htrans_d;
            haddr_q  <= haddr_d;
            hwrite_q <= hwrite_d;
            hsize_q  <= hsize_d;
            hwdata_q <= hwdata_d;
            wdata_q  <= wdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    // next-state: one transfer at a time, advance on hready
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.req_i && !mis_req) state_d = ST_ADDR;
            ST_ADDR: if (bus.hready_i) state_d = ST_DATA;
            ST_DATA: if (bus.hready_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // next values of the registered bus and LSU outputs
    always_comb begin
        htrans_d = htrans_q;
        haddr_d  = haddr_q;
        hwrite_d = hwrite_q;
        hsize_d  = hsize_q;
        hwdata_d = hwdata_q;
        wdata_d  = wdata_q;
        rvalid_d = 1'b0;
        err_d    = 1'b0;
        rdata_d  = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                htrans_d = HTRANS_IDLE;
                if (bus.req_i) begin
                    if (mis_req) begin
                        rvalid_d = 1'b1;
                        err_d    = 1'b1;
                        rdata_d  = '0;
                    end else begin
                        htrans_d = HTRANS_NONSEQ;
                        haddr_d  = bus.addr_i;
                        hwrite_d = bus.we_i;
                        hsize_d  = {1'b0, size_n};
                        wdata_d  = bus.wdata_i;
                    end
                end
            end
            ST_ADDR: begin
                if (bus.hready_i) begin
                    htrans_d = HTRANS_IDLE;
                    hwdata_d = lane_wdata;
                end
            end
            ST_DATA: begin
                htrans_d = HTRANS_IDLE;
                if (bus.hready_i) begin
                    rvalid_d = 1'b1;
                    err_d    = bus.hresp_i;
                    if (bus.hresp_i) rdata_d = '0;
                    else if (!hwrite_q) rdata_d = lane_rdata;
                end
            end
            default: htrans_d = HTRANS_IDLE;
        endcase
    end

    assign bus.gnt_o    = hresetn && bus.req_i && (state_q == ST_IDLE);
    assign bus.rvalid_o = rvalid_q;
    assign bus.err_o    = err_q;
    assign bus.rdata_o  = rdata_q;
    assign bus.haddr_o  = haddr_q;
    assign bus.htrans_o = htrans_q;
    assign bus.hwrite_o = hwrite_q;
    assign bus.hsize_o  = hsize_q;
    assign bus.hburst_o = HBURST_SINGLE;
    assign bus.hwdata_o = hwdata_q;

endmodule

// File: tb/tb_lsu_ahb_master.sv
// Randomised bench for lsu_ahb_master against a transaction-level model.
// Build with +define+LSU_AHB_ALIGN_CHECK_EN to cover the alignment check.
module tb_lsu_ahb_master;

`ifdef LSU_AHB_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   last_ns = 0;
    logic [31:0] model_rdata = 32'h0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lsu_ahb_master_if bus_if ();

    lsu_ahb_master dut (
        .hclk   (clk),
        .hresetn(rst_n),
        .bus    (bus_if.master)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [1:0] norm(input logic [1:0] sz);
        return (sz == 2'd3) ? 2'd2 : sz;
    endfunction

    function automatic bit is_skip(input logic [31:0] a, input logic [1:0] sz);
        logic [1:0] s;
        s = norm(sz);
        if (!ALIGN_EN) return 1'b0;
        if (s == 2'd1) return a[0];
        if (s == 2'd2) return a[1:0] != 2'b00;
        return 1'b0;
    endfunction

    // one LSU transaction; caller is just past a negedge
    task automatic txn(input bit we, input logic [31:0] a, input logic [1:0] sz,
                       input logic [31:0] wd, input int aw, input int dw,
                       input bit er, input logic [31:0] brd, input bit hold,
                       input int exp_gap);
        logic [1:0]  s;
        logic [31:0] exp_wd;
        bit          skip;
        bit          got;
        int          n;
        int          j;
        int          exp_n;
        s = norm(sz);
        skip = is_skip(a, sz);
        if (s == 2'd0) exp_wd = {24'h0, wd[7:0]} * 32'h01010101;
        else if (s == 2'd1) exp_wd = {16'h0, wd[15:0]} * 32'h00010001;
        else exp_wd = wd;
        exp_n = skip ? 1 : 3 + aw + dw + (er ? 1 : 0);
        if (skip || er) model_rdata = 32'h0;
        else if (!we) begin
            if (s == 2'd0) model_rdata = (brd >> (8 * a[1:0])) & 32'hFF;
            else if (s == 2'd1) model_rdata = (brd >> (16 * a[1])) & 32'hFFFF;
            else model_rdata = brd;
        end
        bus_if.req_i = 1'b1;
        bus_if.we_i = we;
        bus_if.addr_i = a;
        bus_if.size_i = sz;
        bus_if.wdata_i = wd;
        bus_if.hready_i = 1'b1;
        bus_if.hresp_i = 1'b0;
        #1;
        chk("gnt", {31'h0, bus_if.gnt_o}, 32'h1);
        n = 0;
        got = 1'b0;
        while (n < 20 && !got) begin
            @(negedge clk);
            n++;
            if (!hold) bus_if.req_i = 1'b0;
            if (bus_if.rvalid_o) begin
                got = 1'b1;
            end else begin
                chk("gnt_busy", {31'h0, bus_if.gnt_o}, 32'h0);
                if (!skip && n <= aw + 1) begin
                    chk("ns", {30'h0, bus_if.htrans_o}, 32'h2);
                    chk("haddr", bus_if.haddr_o, a);
                    if (n == 1) begin
                        chk("hwrite", {31'h0, bus_if.hwrite_o}, {31'h0, we});
                        chk("hsize", {29'h0, bus_if.hsize_o}, {30'h0, s});
                        chk("hburst", {29'h0, bus_if.hburst_o}, 32'h0);
                        if (exp_gap != 0) chk("gap", cyc - last_ns, exp_gap);
                    end
                    last_ns = cyc;
                    bus_if.hready_i = (n == aw + 1);
                    bus_if.hresp_i = 1'b0;
                end else if (!skip) begin
                    j = n - aw - 2;
                    chk("dp_idle", {30'h0, bus_if.htrans_o}, 32'h0);
                    if (we) chk("hwdata", bus_if.hwdata_o, exp_wd);
                    bus_if.hrdata_i = brd;
                    if (er) begin
                        bus_if.hready_i = (j == dw + 1);
                        bus_if.hresp_i = (j >= dw);
                    end else begin
                        bus_if.hready_i = (j >= dw);
                        bus_if.hresp_i = 1'b0;
                    end
                end
            end
        end
        chk("latency", n, exp_n);
        chk("err", {31'h0, bus_if.err_o}, {31'h0, (skip || er)});
        chk("rdata", bus_if.rdata_o, model_rdata);
        if (skip) chk("no_ns", {30'h0, bus_if.htrans_o}, 32'h0);
        bus_if.hready_i = 1'b1;
        bus_if.hresp_i = 1'b0;
    endtask

    // completion pulse must last one cycle, rdata must hold
    task automatic idle_chk();
        bus_if.req_i = 1'b0;
        @(negedge clk);
        chk("rvalid_pulse", {31'h0, bus_if.rvalid_o}, 32'h0);
        chk("err_pulse", {31'h0, bus_if.err_o}, 32'h0);
        chk("rdata_hold", bus_if.rdata_o, model_rdata);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_htrans"}, {30'h0, bus_if.htrans_o}, 32'h0);
        chk({tag, "_haddr"}, bus_if.haddr_o, 32'h0);
        chk({tag, "_hwrite"}, {31'h0, bus_if.hwrite_o}, 32'h0);
        chk({tag, "_hsize"}, {29'h0, bus_if.hsize_o}, 32'h0);
        chk({tag, "_hburst"}, {29'h0, bus_if.hburst_o}, 32'h0);
        chk({tag, "_hwdata"}, bus_if.hwdata_o, 32'h0);
        chk({tag, "_gnt"}, {31'h0, bus_if.gnt_o}, 32'h0);
        chk({tag, "_rvalid"}, {31'h0, bus_if.rvalid_o}, 32'h0);
        chk({tag, "_rdata"}, bus_if.rdata_o, 32'h0);
        chk({tag, "_err"}, {31'h0, bus_if.err_o}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          we;
        bit          er;
        bit          hold;
        bit          prev_hold;
        int          aw;
        int          dw;
        int          gap;
        int          prev_gap;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] brd;

        rst_n = 1'b0;
        bus_if.req_i = 1'b1;
        bus_if.we_i = 1'b0;
        bus_if.addr_i = 32'h0;
        bus_if.size_i = 2'd0;
        bus_if.wdata_i = 32'h0;
        bus_if.hready_i = 1'b1;
        bus_if.hresp_i = 1'b0;
        bus_if.hrdata_i = 32'h0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        bus_if.req_i = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // zero-wait word store
        txn(1, 32'h1000_0004, 2'd2, 32'hDEADBEEF, 0, 0, 0, 32'h0, 0, 0);
        idle_chk();
        // byte load, two data-phase waits
        txn(0, 32'h1000_0002, 2'd0, 32'h0, 0, 2, 0, 32'h11223344, 0, 0);
        idle_chk();
        // half store, address-phase wait
        txn(1, 32'h1000_0010, 2'd1, 32'h0000ABCD, 1, 0, 0, 32'h0, 0, 0);
        idle_chk();
        // two-cycle ERROR on a load
        txn(0, 32'h1000_0020, 2'd2, 32'h0, 0, 0, 1, 32'hCAFEF00D, 0, 0);
        idle_chk();
        // back-to-back with req held high
        txn(1, 32'h1000_0030, 2'd2, 32'h01234567, 0, 0, 0, 32'h0, 1, 0);
        txn(0, 32'h1000_0034, 2'd2, 32'h0, 0, 0, 0, 32'h89ABCDEF, 0, 3);
        idle_chk();

        // reset while in the data phase
        bus_if.req_i = 1'b1;
        bus_if.we_i = 1'b0;
        bus_if.addr_i = 32'h1000_0040;
        bus_if.size_i = 2'd2;
        @(negedge clk);
        bus_if.req_i = 1'b0;
        bus_if.hready_i = 1'b1;
        @(negedge clk);
        bus_if.hready_i = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_vals("mid");
        rst_n = 1'b1;
        bus_if.hready_i = 1'b1;
        model_rdata = 32'h0;
        repeat (2) begin
            @(negedge clk);
            chk("mid_no_rvalid", {31'h0, bus_if.rvalid_o}, 32'h0);
            chk("mid_idle", {30'h0, bus_if.htrans_o}, 32'h0);
        end

        // misaligned word load
        txn(0, 32'h1000_0042, 2'd2, 32'h0, 0, 0, 0, 32'h55667788, 0, 0);
        idle_chk();

        // randomised traffic
        prev_hold = 1'b0;
        prev_gap = 0;
        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (norm(sz) == 2'd1) a[0] = 1'b0;
                if (norm(sz) == 2'd2) a[1:0] = 2'b00;
            end
            wd = $urandom;
            brd = $urandom;
            aw = $urandom_range(0, 2);
            dw = $urandom_range(0, 2);
            er = ($urandom_range(0, 4) == 0);
            hold = (i != 59) && !is_skip(a, sz) && ($urandom_range(0, 1) == 1);
            gap = (prev_hold && !is_skip(a, sz)) ? prev_gap : 0;
            txn(we, a, sz, wd, aw, dw, er, brd, hold, gap);
            prev_hold = hold;
            prev_gap = dw + (er ? 1 : 0) + 3;
            if (!hold) begin
                idle_chk();
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
